mem_stage: RTL

//  Pipeline stage directly downstream of EX. Registers the EX result and memory request.

---
 rtl/mem_stage_pkg.sv | 18 +
 rtl/mem_bus_ctrl.sv | 89 ++++++++
 rtl/mem_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Purpose: state and exception encodings shared by the MEM stage and its bus controller.
// Latency: none (types and constants only).
// Backpressure: none.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        MS_IDLE  = 2'd0,
        MS_REQ   = 2'd1,
        MS_WAIT  = 2'd2,
        MS_DRAIN = 2'd3
    } ms_state_t;

    // mem_exc is {ades, adel}
    localparam logic [1:0] MEM_EXC_NONE = 2'b00;
    localparam logic [1:0] MEM_EXC_ADEL = 2'b01;
    localparam logic [1:0] MEM_EXC_ADES = 2'b10;

endpackage

// File: rtl/mem_bus_ctrl.sv
// Purpose: req/gnt/rvalid data-bus sequencer for one word access at a time.
// Latency: done fires in the cycle d_rvalid arrives (earliest: the first REQ cycle).
// Backpressure: idle low from start until the access completes or is drained.
module mem_bus_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              start_we,
    input  logic [DATA_W-1:0] start_addr,
    input  logic [DATA_W-1:0] start_wdata,
    input  logic              abort,
    output logic              idle,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              d_req,
    output logic              d_we,
    output logic [DATA_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_wdata,
    input  logic              d_gnt,
    input  logic              d_rvalid,
    input  logic [DATA_W-1:0] d_rdata
);

    ms_state_t state_q, state_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= MS_IDLE;
            d_we    <= 1'b0;
            d_addr  <= '0;
            d_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (start && state_q == MS_IDLE) begin
                d_we    <= start_we;
                d_addr  <= start_addr;
                d_wdata <= start_wdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        d_req   = 1'b0;
        case (state_q)
            MS_IDLE: begin
                if (start) state_d = MS_REQ;
            end
            MS_REQ: begin
                if (abort) begin
                    // A grant that lands anyway leaves the access in flight on the bus.
                    if (d_gnt && !d_rvalid) state_d = MS_DRAIN;
                    else                    state_d = MS_IDLE;
                end else begin
                    d_req = 1'b1;
                    if (d_gnt) begin
                        if (d_rvalid) begin
                            done    = 1'b1;
                            state_d = MS_IDLE;
                        end else begin
                            state_d = MS_WAIT;
                        end
                    end
                end
            end
            MS_WAIT: begin
                if (d_rvalid) begin
                    done    = !abort;
                    state_d = MS_IDLE;
                end else if (abort) begin
                    state_d = MS_DRAIN;
                end
            end
            MS_DRAIN: begin
                if (d_rvalid) state_d = MS_IDLE;
            end
            default: state_d = MS_IDLE;
        endcase
    end

    assign idle  = (state_q == MS_IDLE);
    assign rdata = d_rdata;

endmodule

// File: rtl/mem_stage.sv
// Purpose: MEM pipeline stage; registers EX results, runs LW/SW on the data bus, feeds WB.
// Latency: 1 cycle for non-memory ops; capture + REQ + retire (minimum) for LW/SW.
// Backpressure: ex_ready low while a bus access is outstanding. MEM_ALIGN_CHECK_EN adds address-alignment exceptions.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    input  logic               ex_valid,
    output logic               ex_ready,
    input  logic [DATA_W-1:0]  ex_alures,
    input  logic               ex_is_load,
    input  logic               ex_m_wen,
    input  logic [DATA_W-1:0]  ex_m_addr,
    input  logic [DATA_W-1:0]  ex_m_dout,
    input  logic               ex_wreg,
    input  logic [RADDR_W-1:0] ex_waddr,
    output logic               d_req,
    output logic               d_we,
    output logic [DATA_W-1:0]  d_addr,
    output logic [DATA_W-1:0]  d_wdata,
    input  logic               d_gnt,
    input  logic               d_rvalid,
    input  logic [DATA_W-1:0]  d_rdata,
    output logic               wb_valid,
    output logic               wb_wreg,
    output logic [RADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0]  wb_wdata,
    output logic [1:0]         mem_exc
);

    logic               idle, done, capture, is_mem, misalign, start;
    logic [DATA_W-1:0]  rdata;
    logic               ld_q, wreg_q;
    logic [RADDR_W-1:0] waddr_q;

    assign ex_ready = idle;
    assign capture  = ex_valid && !flush && idle;
    assign is_mem   = ex_is_load || ex_m_wen;
`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = is_mem && (ex_m_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign start    = capture && is_mem && !misalign;

    mem_bus_ctrl #(
        .DATA_W(DATA_W)
    ) u_bus (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .start_we   (ex_m_wen),
        .start_addr (ex_m_addr),
        .start_wdata(ex_m_dout),
        .abort      (flush),
        .idle       (idle),
        .done       (done),
        .rdata      (rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_valid <= 1'b0;
            wb_wreg  <= 1'b0;
            wb_waddr <= '0;
            wb_wdata <= '0;
            mem_exc  <= MEM_EXC_NONE;
            ld_q     <= 1'b0;
            wreg_q   <= 1'b0;
            waddr_q  <= '0;
        end else begin
            wb_valid <= 1'b0;
            wb_wreg  <= 1'b0;
            mem_exc  <= MEM_EXC_NONE;
            if (capture && !is_mem) begin
                wb_valid <= 1'b1;
                wb_wreg  <= ex_wreg;
                wb_waddr <= ex_waddr;
                wb_wdata <= ex_alures;
            end else if (capture && misalign) begin
                // Faulting address goes to WB so the exception handler can report it.
                wb_valid <= 1'b1;
                wb_waddr <= ex_waddr;
                wb_wdata <= ex_m_addr;
                mem_exc  <= ex_is_load ? MEM_EXC_ADEL : MEM_EXC_ADES;
            end else if (start) begin
                ld_q    <= ex_is_load;
                wreg_q  <= ex_wreg;
                waddr_q <= ex_waddr;
            end
            if (done) begin
                wb_valid <= 1'b1;
                wb_wreg  <= ld_q && wreg_q;
                wb_waddr <= waddr_q;
                if (ld_q) wb_wdata <= rdata;
            end
        end
    end

endmodule
